e0c6s46_cpu: RTL and testbench
==============================

Name: e0c6s46_cpu

Overview:
- Multi-cycle, sequencer-driven 4-bit CPU core, instruction-compatible with a subset of the Epson E0C6S46 (Tamagotchi SoC).
- Fetches 12-bit opcodes from program ROM over a 13-bit address bus.
- Reads and writes 4-bit data memory over a 12-bit address bus.
- Sits between the ROM, the RAM/IO decoder and the top-level clock/reset.

Parameters:
- RESET_PC, 13'h0100, PC value loaded on reset (bank 0, page 1, step 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  13  program address = PC.
- rom_data  input  12  opcode; valid the cycle after rom_addr is presented.
- memory_write_en  output  1  RAM write strobe, one cycle per nibble.
- memory_addr  output  12  RAM address.
- memory_write_data  output  4  RAM write nibble.
- memory_read_data  input  4  RAM read nibble; valid the cycle after memory_addr is presented with write_en low.

Behaviour:
- Architectural registers, individually named and observable/forceable by the bench: pc[12:0] ({PCB, PCP[3:0], PCS[7:0]}), np[4:0] ({NBP, NPP}), a, b (4b), x, y (12b, {XP, XH, XL}), sp (8b), flags zero, carry, decimal, interrupt.
- Reset (clk edge with reset=1): pc=RESET_PC, np=5'h01, a=b=0, x=y=0, sp=0, all flags 0, sequencer to FETCH, memory_write_en=0. Reset mid-instruction aborts the instruction; no partial register commit after the reset edge.
- Sequencer states: FETCH -> DECODE -> EXEC[0..n] -> FETCH.
  - FETCH (1 clk): rom_addr=pc.
  - DECODE (1 clk): latch rom_data into IR; PCS increments mod 256 with no carry into PCP.
  - EXEC: instruction-specific steps. Status signal last_cycle_step is high in the final EXEC step.
- After every instruction except PSET: np <= pc[12:8] of the resulting PC. PSET leaves np as loaded.
- Jump target is {np, s} using np as held at the start of the instruction.
- Opcode subset (all others execute as 1-step NOP):
  - 0x0ss JP s: pc <= {np, s}.
  - 0x2ss JP C,s: jump if carry=1.
  - 0x3ss JP NC,s: jump if carry=0.
  - 0x6ss JP Z,s: jump if zero=1.
  - 0x7ss JP NZ,s: jump if zero=0.
  - Not-taken conditional jumps leave the incremented pc. All jumps take 1 EXEC step.
  - 0xBee LD X,e: x[7:0] <= e, XP unchanged. 1 step.
  - 0x8ee LD Y,e: y[7:0] <= e, XP unchanged. 1 step.
  - 0xE0i LD A,i: a <= i. 1 step.
  - 0xE40-0xE5F PSET p: np <= p[4:0]. 1 step.
  - 0x1ll RETD l, 6 EXEC steps:
    - read M(sp) -> PCSL;
    - read M(sp+1) -> PCSH;
    - read M(sp+2) -> PCP;
    - pc <= {pc[12], PCP, PCSH, PCSL}, sp <= sp+3;
    - write M(x) <= l[3:0];
    - write M(x+1) <= l[7:4];
    - x[7:0] <= x[7:0]+2 (wraps mod 256, XP unchanged).
- Address arithmetic:
  - sp+k wraps mod 256; the stack address is {4'h0, sp}.
  - x+1 increments only x[7:0].
- memory_write_en is high only on RETD write steps; otherwise 0. memory_addr holds the current step's address.
- Flags are not modified by this subset.

Test Plan:
- Reset: hold reset 2 clks -> pc=0x0100, np=0x01, memory_write_en=0, rom_addr=0x0100.
- JP: np=5'h12, opcode 0x045 -> pc=0x1245, np=0x12 after completion. Opcode 0x023 with np=0x01 -> pc=0x0123.
- RETD:
  - Setup: x=0x4F1, sp=0x44, RAM[44]=D, [45]=4, [46]=7, pc bank 0; opcode 0x1FC.
  - Expect: pc=0x074D, sp=0x47, RAM[4F1]=C, RAM[4F2]=F, x=0x4F3, y/a/b unchanged.
- Conditional jumps: carry=0, opcode 0x2CD -> pc = fetched pc+1, no jump. Set carry=1 -> pc={np,0xCD}. JP Z/NZ similarly with zero flag.
- PSET then JP: 0xE53 then 0x010 -> np=0x13, pc=0x1310. Wraps: x=0x4FF, RETD -> writes 0x4FF and 0x400, x=0x401.
- Reset asserted during RETD EXEC step 4 -> no RAM write occurs after the reset edge; all registers hold reset values.

Source files
------------

// File: rtl/e0c6s46_cpu.sv
// Multi-cycle 4-bit core executing a subset of the Epson E0C6S46 instruction set.
// A FETCH/DECODE/EXEC sequencer drives the ROM and RAM buses one nibble per step.
module e0c6s46_cpu #(
    parameter logic [12:0] RESET_PC = 13'h0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic        memory_write_en,
    output logic [11:0] memory_addr,
    output logic [3:0]  memory_write_data,
    input  logic [3:0]  memory_read_data
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC} seq_state_t;

    seq_state_t  state, state_next;
    logic [2:0]  step;
    logic [11:0] ir;

    logic [12:0] pc, pc_next;
    logic [4:0]  np;
    logic [3:0]  a, b;
    logic [11:0] x, y;
    logic [7:0]  sp;
    logic        zero, carry, decimal, interrupt;

    logic [3:0]  pcsl, pcsh;
    logic        is_retd, is_pset, jump_taken, last_cycle_step;
    logic [7:0]  sp_plus1, sp_plus2, xl_plus1;

    logic unused_state;
    assign unused_state = ^{a, b, y, decimal, interrupt};

    assign rom_addr = pc;
    assign sp_plus1 = sp + 8'd1;
    assign sp_plus2 = sp + 8'd2;
    assign xl_plus1 = x[7:0] + 8'd1;

    always_comb begin
        is_retd         = (ir[11:8] == 4'h1);
        is_pset         = (ir[11:5] == 7'b1110_010);
        last_cycle_step = (state == EXEC) && (!is_retd || step == 3'd5);
        case (ir[11:8])
            4'h0:    jump_taken = 1'b1;
            4'h2:    jump_taken = carry;
            4'h3:    jump_taken = !carry;
            4'h6:    jump_taken = zero;
            4'h7:    jump_taken = !zero;
            default: jump_taken = 1'b0;
        endcase

        pc_next = pc;
        if (state == EXEC) begin
            if (jump_taken)
                pc_next = {np, ir[7:0]};
            else if (is_retd && step == 3'd3)
                pc_next = {pc[12], memory_read_data, pcsh, pcsl};
        end

        state_next = state;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = last_cycle_step ? FETCH : EXEC;
            default: state_next = FETCH;
        endcase
    end

    // A write step suppressed by reset must not reach RAM on the reset edge itself.
    always_comb begin
        memory_addr       = {4'h0, sp};
        memory_write_en   = 1'b0;
        memory_write_data = 4'h0;
        if (state == EXEC && is_retd) begin
            case (step)
                3'd1: memory_addr = {4'h0, sp_plus1};
                3'd2: memory_addr = {4'h0, sp_plus2};
                3'd4: begin
                    memory_addr       = x;
                    memory_write_en   = !reset;
                    memory_write_data = ir[3:0];
                end
                3'd5: begin
                    memory_addr       = {x[11:8], xl_plus1};
                    memory_write_en   = !reset;
                    memory_write_data = ir[7:4];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            step      <= 3'd0;
            ir        <= 12'h000;
            pc        <= RESET_PC;
            np        <= 5'h01;
            a         <= 4'h0;
            b         <= 4'h0;
            x         <= 12'h000;
            y         <= 12'h000;
            sp        <= 8'h00;
            zero      <= 1'b0;
            carry     <= 1'b0;
            decimal   <= 1'b0;
            interrupt <= 1'b0;
            pcsl      <= 4'h0;
            pcsh      <= 4'h0;
        end else begin
            state <= state_next;
            case (state)
                DECODE: begin
                    ir      <= rom_data;
                    pc[7:0] <= pc[7:0] + 8'd1;
                    step    <= 3'd0;
                end
                EXEC: begin
                    pc   <= pc_next;
                    step <= step + 3'd1;
                    if (is_retd) begin
                        if (step == 3'd1) pcsl <= memory_read_data;
                        if (step == 3'd2) pcsh <= memory_read_data;
                        if (step == 3'd3) sp <= sp + 8'd3;
                        if (step == 3'd5) x[7:0] <= x[7:0] + 8'd2;
                    end
                    if (ir[11:8] == 4'hB) x[7:0] <= ir[7:0];
                    if (ir[11:8] == 4'h8) y[7:0] <= ir[7:0];
                    if (ir[11:4] == 8'hE0) a <= ir[3:0];
                    // PSET preloads the page for the next jump, so it must not be overwritten here.
                    if (is_pset)
                        np <= ir[4:0];
                    else if (last_cycle_step)
                        np <= pc_next[12:8];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e0c6s46_cpu.sv
// Scoreboard bench for e0c6s46_cpu: directed programs push expected register
// snapshots and RAM writes; monitors compare them as the core produces them.
module tb_e0c6s46_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic        memory_write_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;

    logic        preload_en;
    logic [11:0] preload_addr;
    logic [3:0]  preload_data;

    logic [11:0] rom [0:8191];
    logic [3:0]  ram [0:4095];

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [12:0] pc;
        logic [4:0]  np;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  sp;
        logic [3:0]  a;
    } snap_t;

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  data;
    } wr_t;

    snap_t exp_q[$];
    wr_t   wr_q[$];
    logic  pending = 1'b0;

    always #5 clk = ~clk;

    e0c6s46_cpu #(.RESET_PC(13'h0100)) dut (
        .clk               (clk),
        .reset             (reset),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .memory_write_en   (memory_write_en),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        if (preload_en)
            ram[preload_addr] <= preload_data;
        else if (memory_write_en)
            ram[memory_addr] <= memory_write_data;
        memory_read_data <= ram[memory_addr];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [12:0] addr, input logic [11:0] op,
                                  input logic [12:0] pc, input logic [4:0] np, input logic [11:0] x,
                                  input logic [11:0] y, input logic [7:0] sp, input logic [3:0] a);
        snap_t s;
        rom[addr] = op;
        s.name = name; s.pc = pc; s.np = np; s.x = x; s.y = y; s.sp = sp; s.a = a;
        exp_q.push_back(s);
    endtask

    task automatic expect_write(input logic [11:0] addr, input logic [3:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic preload(input logic [11:0] addr, input logic [3:0] data);
        preload_en   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8192; i++) rom[i] = 12'hFFF;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && wr_q.size() == 0) break;
        end
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got %0d/%0d pending want 0/0", name, exp_q.size(), wr_q.size());
            exp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_rom();
    endtask

    // Register snapshot is taken the cycle after the final EXEC step has committed.
    always @(negedge clk) begin
        snap_t e;
        if (pending && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({dut.pc, dut.np, dut.x, dut.y, dut.sp, dut.a} !== {e.pc, e.np, e.x, e.y, e.sp, e.a}) begin
                bad++;
                $display("[TB] FAIL %s: got pc=%h np=%h x=%h y=%h sp=%h a=%h want pc=%h np=%h x=%h y=%h sp=%h a=%h",
                         e.name, dut.pc, dut.np, dut.x, dut.y, dut.sp, dut.a, e.pc, e.np, e.x, e.y, e.sp, e.a);
            end
        end
        pending = dut.last_cycle_step && !reset;
    end

    always @(negedge clk) begin
        wr_t w;
        if (memory_write_en && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            total++;
            if ({memory_addr, memory_write_data} !== {w.addr, w.data}) begin
                bad++;
                $display("[TB] FAIL ram_write: got %h<=%h want %h<=%h", memory_addr, memory_write_data, w.addr, w.data);
            end
        end
    end

    initial begin
        logic found;
        reset        = 1'b1;
        preload_en   = 1'b0;
        preload_addr = 12'h000;
        preload_data = 4'h0;
        clear_rom();
        repeat (2) @(negedge clk);
        check_output("reset_pc", 32'(dut.pc), 32'h0100);
        check_output("reset_np", 32'(dut.np), 32'h01);
        check_output("reset_we", 32'(memory_write_en), 32'h0);
        check_output("reset_rom_addr", 32'(rom_addr), 32'h0100);
        check_output("reset_x_sp_a", 32'({dut.x, dut.sp, dut.a}), 32'h0);

        // Jumps, page selection and immediate loads.
        apply_stimulus("pset_12",   13'h0100, 12'hE52, 13'h0101, 5'h12, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jp_45",     13'h0101, 12'h045, 13'h1245, 5'h12, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("pset_01",   13'h1245, 12'hE41, 13'h1246, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jp_23",     13'h1246, 12'h023, 13'h0123, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpc_nt",    13'h0123, 12'h2CD, 13'h0124, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("pset_13",   13'h0124, 12'hE53, 13'h0125, 5'h13, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jp_10",     13'h0125, 12'h010, 13'h1310, 5'h13, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("ld_a",      13'h1310, 12'hE07, 13'h1311, 5'h13, 12'h000, 12'h000, 8'h00, 4'h7);
        apply_stimulus("ld_x",      13'h1311, 12'hB12, 13'h1312, 5'h13, 12'h012, 12'h000, 8'h00, 4'h7);
        apply_stimulus("ld_y",      13'h1312, 12'h834, 13'h1313, 5'h13, 12'h012, 12'h034, 8'h00, 4'h7);
        reset = 1'b0;
        wait_done("phase_jp", 200);
        enter_reset();

        // Conditional jumps with carry=1, zero=1.
        apply_stimulus("jpc_t",     13'h0100, 12'h2CD, 13'h01CD, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpnc_nt",   13'h01CD, 12'h3AA, 13'h01CE, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpz_t",     13'h01CE, 12'h6F0, 13'h01F0, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpnz_nt",   13'h01F0, 12'h711, 13'h01F1, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        reset = 1'b0;
        force dut.carry = 1'b1;
        force dut.zero  = 1'b1;
        @(negedge clk);
        release dut.carry;
        release dut.zero;
        wait_done("phase_cc1", 200);
        enter_reset();

        // Conditional jumps with both flags clear.
        apply_stimulus("jpz_nt",    13'h0100, 12'h611, 13'h0101, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpnz_t",    13'h0101, 12'h755, 13'h0155, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        apply_stimulus("jpnc_t",    13'h0155, 12'h3AA, 13'h01AA, 5'h01, 12'h000, 12'h000, 8'h00, 4'h0);
        reset = 1'b0;
        wait_done("phase_cc0", 200);
        enter_reset();

        // RETD, including the x low-byte wrap.
        preload(12'h044, 4'hD); preload(12'h045, 4'h4); preload(12'h046, 4'h7);
        preload(12'h047, 4'h2); preload(12'h048, 4'h5); preload(12'h049, 4'h0);
        apply_stimulus("ld_y_a5",   13'h0100, 12'h8A5, 13'h0101, 5'h01, 12'h4F1, 12'h0A5, 8'h44, 4'h0);
        apply_stimulus("ld_a_9",    13'h0101, 12'hE09, 13'h0102, 5'h01, 12'h4F1, 12'h0A5, 8'h44, 4'h9);
        apply_stimulus("retd_fc",   13'h0102, 12'h1FC, 13'h074D, 5'h07, 12'h4F3, 12'h0A5, 8'h47, 4'h9);
        expect_write(12'h4F1, 4'hC);
        expect_write(12'h4F2, 4'hF);
        apply_stimulus("ld_x_ff",   13'h074D, 12'hBFF, 13'h074E, 5'h07, 12'h4FF, 12'h0A5, 8'h47, 4'h9);
        apply_stimulus("retd_wrap", 13'h074E, 12'h121, 13'h0052, 5'h00, 12'h401, 12'h0A5, 8'h4A, 4'h9);
        expect_write(12'h4FF, 4'h1);
        expect_write(12'h400, 4'h2);
        reset = 1'b0;
        force dut.x  = 12'h4F1;
        force dut.sp = 8'h44;
        @(negedge clk);
        release dut.x;
        release dut.sp;
        wait_done("phase_retd", 300);
        check_output("ram_4f1", 32'(ram[12'h4F1]), 32'hC);
        check_output("ram_4f2", 32'(ram[12'h4F2]), 32'hF);
        enter_reset();

        // Stack wrap, then a reset landing on the first RETD write step.
        preload(12'h0FE, 4'h3); preload(12'h0FF, 4'h8); preload(12'h000, 4'h2);
        preload(12'h001, 4'h0); preload(12'h002, 4'h0); preload(12'h003, 4'h0);
        preload(12'h012, 4'h5); preload(12'h013, 4'h6);
        apply_stimulus("retd_spwrap", 13'h0100, 12'h1AB, 13'h0283, 5'h02, 12'h012, 12'h000, 8'h01, 4'h0);
        expect_write(12'h010, 4'hB);
        expect_write(12'h011, 4'hA);
        rom[13'h0283] = 12'h1CD;
        reset = 1'b0;
        force dut.x  = 12'h010;
        force dut.sp = 8'hFE;
        @(negedge clk);
        release dut.x;
        release dut.sp;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (memory_write_en && memory_addr == 12'h012) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        check_output("abort_reached", 32'(found), 32'h1);
        check_output("abort_drained", 32'(exp_q.size() + wr_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        check_output("abort_ram_012", 32'(ram[12'h012]), 32'h5);
        check_output("abort_ram_013", 32'(ram[12'h013]), 32'h6);
        check_output("abort_pc", 32'(dut.pc), 32'h0100);
        check_output("abort_regs", 32'({dut.np, dut.x, dut.sp}), 32'({5'h01, 12'h000, 8'h00}));
        check_output("abort_we", 32'(memory_write_en), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
